// File: rtl/ttt_move_engine.sv
// ttt_move_engine: multi-cycle CPU move selector for an N x N tic-tac-toe board.
// A request snapshots the board, scans every line for win/block candidates
// (skipped in easy mode), scans every cell for fallbacks, then reports one move.
// Optional build macro CPU_RAND_EN: rotates the cell scan start by an LFSR value.
module ttt_move_engine #(
    parameter int          N         = 3,
    parameter logic [15:0] RAND_SEED = 16'hACE1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic [1:0]                difficulty,
    input  logic [2*N*N-1:0]          board,
    output logic                      busy,
    output logic                      done,
    output logic                      move_valid,
    output logic [$clog2(N*N)-1:0]    move_idx
);

    localparam int NC  = N * N;
    localparam int IW  = $clog2(NC);
    localparam int NL  = 2 * N + 2;
    localparam int LW  = $clog2(NL);
    localparam int CW  = $clog2(N + 1);
    localparam int CTR = (NC - 1) / 2;
    localparam int K0  = 0;
    localparam int K1  = N - 1;
    localparam int K2  = NC - N;
    localparam int K3  = NC - 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LINES = 2'd1;
    localparam logic [1:0] S_CELLS = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // A zero seed would lock the LFSR, and N outside 3..8 is unsupported.
    generate
        if (N < 3 || N > 8 || RAND_SEED == 16'h0000) begin : g_bad_config
            $error("ttt_move_engine: N must be 3..8 and RAND_SEED nonzero");
        end
    endgenerate

    logic [1:0]        state;
    logic [2*NC-1:0]   snap_board;
    logic [1:0]        mode;
    logic [LW-1:0]     line_cnt;
    logic [IW-1:0]     cell_cnt;
    logic [IW-1:0]     cell_idx;
    logic              win_found, block_found, first_found, adj_found;
    logic [IW-1:0]     win_idx, block_idx, first_idx, adj_idx;
    logic [CW-1:0]     line_cpu, line_hum, line_emp;
    logic [IW-1:0]     line_first;
    logic              cell_empty, cell_adj;
    logic              sel_valid;
    logic [IW-1:0]     sel_idx;

`ifdef CPU_RAND_EN
    logic [15:0]       lfsr;
    logic [IW-1:0]     offset;
    logic [IW:0]       cell_sum;

    // Free-running Fibonacci LFSR (taps 16,14,13,11) and scan offset capture on accept.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lfsr   <= RAND_SEED;
            offset <= '0;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            if (state == S_IDLE && start) begin
                offset <= IW'(lfsr % 16'(NC));
            end
        end
    end

    // Rotated cell index: (offset + cnt) mod NC without a divider.
    always_comb begin
        cell_sum = {1'b0, offset} + {1'b0, cell_cnt};
        if (cell_sum >= (IW+1)'(NC)) begin
            cell_idx = IW'(cell_sum - (IW+1)'(NC));
        end else begin
            cell_idx = IW'(cell_sum);
        end
    end
`else
    assign cell_idx = cell_cnt;
`endif

    // Count cpu/human/empty cells on the current line and note its lowest empty cell.
    always_comb begin
        int ci;
        int li;
        line_cpu   = '0;
        line_hum   = '0;
        line_emp   = '0;
        line_first = '0;
        li         = int'(line_cnt);
        for (int j = 0; j < N; j++) begin
            if (li < N) begin
                ci = li * N + j;
            end else if (li < 2 * N) begin
                ci = j * N + (li - N);
            end else if (li == 2 * N) begin
                ci = j * N + j;
            end else begin
                ci = j * N + (N - 1 - j);
            end
            case (snap_board[2*ci +: 2])
                2'b00: begin
                    if (line_emp == '0) begin
                        line_first = IW'(ci);
                    end
                    line_emp = line_emp + CW'(1);
                end
                2'b01:   line_hum = line_hum + CW'(1);
                2'b10:   line_cpu = line_cpu + CW'(1);
                default: line_cpu = line_cpu;
            endcase
        end
    end

    // Classify the current scan cell: empty, and whether a human sits orthogonally next to it.
    always_comb begin
        int ci;
        int r;
        int c;
        ci         = int'(cell_idx);
        r          = ci / N;
        c          = ci % N;
        cell_empty = (snap_board[2*ci +: 2] == 2'b00);
        cell_adj   = 1'b0;
        if (r > 0) begin
            if (snap_board[2*(ci-N) +: 2] == 2'b01) cell_adj = 1'b1;
        end
        if (r < N - 1) begin
            if (snap_board[2*(ci+N) +: 2] == 2'b01) cell_adj = 1'b1;
        end
        if (c > 0) begin
            if (snap_board[2*(ci-1) +: 2] == 2'b01) cell_adj = 1'b1;
        end
        if (c < N - 1) begin
            if (snap_board[2*(ci+1) +: 2] == 2'b01) cell_adj = 1'b1;
        end
    end

    // Pick the final move from the collected candidates according to the latched mode.
    always_comb begin
        sel_valid = first_found;
        sel_idx   = first_found ? first_idx : '0;
        if (mode == 2'd1) begin
            if (block_found) begin
                sel_idx = block_idx;
            end else if (adj_found) begin
                sel_idx = adj_idx;
            end
        end else if (mode != 2'd0) begin
            if (win_found) begin
                sel_idx = win_idx;
            end else if (block_found) begin
                sel_idx = block_idx;
            end else if ((N % 2 == 1) && snap_board[2*CTR +: 2] == 2'b00) begin
                sel_idx = IW'(CTR);
            end else if (snap_board[2*K0 +: 2] == 2'b00) begin
                sel_idx = IW'(K0);
            end else if (snap_board[2*K1 +: 2] == 2'b00) begin
                sel_idx = IW'(K1);
            end else if (snap_board[2*K2 +: 2] == 2'b00) begin
                sel_idx = IW'(K2);
            end else if (snap_board[2*K3 +: 2] == 2'b00) begin
                sel_idx = IW'(K3);
            end
        end
    end

    // Main sequencer: IDLE -> LINES -> CELLS -> DONE, collecting candidates along the way.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            snap_board  <= '0;
            mode        <= '0;
            line_cnt    <= '0;
            cell_cnt    <= '0;
            win_found   <= 1'b0;
            block_found <= 1'b0;
            first_found <= 1'b0;
            adj_found   <= 1'b0;
            win_idx     <= '0;
            block_idx   <= '0;
            first_idx   <= '0;
            adj_idx     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            move_valid  <= 1'b0;
            move_idx    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        snap_board  <= board;
                        mode        <= difficulty;
                        busy        <= 1'b1;
                        line_cnt    <= '0;
                        cell_cnt    <= '0;
                        win_found   <= 1'b0;
                        block_found <= 1'b0;
                        first_found <= 1'b0;
                        adj_found   <= 1'b0;
                        win_idx     <= '0;
                        block_idx   <= '0;
                        first_idx   <= '0;
                        adj_idx     <= '0;
                        state       <= (difficulty == 2'd0) ? S_CELLS : S_LINES;
                    end
                end
                S_LINES: begin
                    if (line_cpu == CW'(N-1) && line_emp == CW'(1) && !win_found) begin
                        win_found <= 1'b1;
                        win_idx   <= line_first;
                    end
                    if (line_hum == CW'(N-1) && line_emp == CW'(1) && !block_found) begin
                        block_found <= 1'b1;
                        block_idx   <= line_first;
                    end
                    if (line_cnt == LW'(NL-1)) begin
                        line_cnt <= '0;
                        state    <= S_CELLS;
                    end else begin
                        line_cnt <= line_cnt + LW'(1);
                    end
                end
                S_CELLS: begin
                    if (cell_empty && !first_found) begin
                        first_found <= 1'b1;
                        first_idx   <= cell_idx;
                    end
                    if (cell_empty && cell_adj && !adj_found) begin
                        adj_found <= 1'b1;
                        adj_idx   <= cell_idx;
                    end
                    if (cell_cnt == IW'(NC-1)) begin
                        cell_cnt <= '0;
                        state    <= S_DONE;
                    end else begin
                        cell_cnt <= cell_cnt + IW'(1);
                    end
                end
                default: begin
                    done       <= 1'b1;
                    busy       <= 1'b0;
                    move_valid <= sel_valid;
                    move_idx   <= sel_idx;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule
